stepper_batch_ctrl: RTL and testbench
=====================================

Name: stepper_batch_ctrl

Overview:
- Parametrised object-batch controller for the conveyor/stepper station.
- Counts debounced rising edges from an IR sensor. At a programmable target count, it drives a 28BYJ-48 stepper for a programmable time in half- or full-step mode, in either direction.
- Adds a cooldown lock-out, an abort input, a done pulse and a BCD 7-segment count display.
- Drives the station LEDs and the pulsed buzzer.

Parameters:
- CLK_FREQ_HZ, 25_000_000, system clock frequency.
- TARGET_COUNT, 5, objects per batch (1..15).
- COUNT_W, 4, width of the object counter.
- DEBOUNCE_CYC, CLK_FREQ_HZ/1000*20, cycles the synchronised sensor must be stable before the filtered value changes.
- STEP_CYC, CLK_FREQ_HZ/1000, cycles per motor step.
- RUN_CYC, CLK_FREQ_HZ*10, cycles spent in RUNNING.
- COOLDOWN_CYC, CLK_FREQ_HZ*2, cycles spent in COOLDOWN.
- TONE_HALF_CYC, CLK_FREQ_HZ/4000, half-period of the buzzer tone (2 kHz).
- BLINK_HALF_CYC, CLK_FREQ_HZ/2, half-period of the buzzer gate (1 Hz).

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- sensor  in  1  asynchronous IR sensor; 1 = object present.
- abort  in  1  synchronous; forces return to IDLE.
- half_step  in  1  1 = 8-phase half-step, 0 = 4-phase full-step.
- dir  in  1  1 = forward (index +), 0 = reverse (index -).
- coils  out  4  {in1,in2,in3,in4} stepper drive.
- count  out  COUNT_W  current object count.
- busy  out  1  high in RUNNING or COOLDOWN.
- done  out  1  one-cycle pulse when RUNNING ends normally.
- led_red, led_green  out  1 each  status LEDs.
- buzzer  out  1  gated tone.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset: all flops cleared on the cycle rst is sampled high. Output values:
  - state IDLE, count 0, coils 0000, busy 0, done 0, buzzer 0.
  - led_green 1, led_red 0, seg 1000000 ("0").
  - Synchroniser and filtered sensor reset to 0.
  - rst mid-operation behaves identically.
- Input path:
  - sensor passes through a 2-flop synchroniser.
  - filtered takes the synchronised value after DEBOUNCE_CYC consecutive cycles of disagreement.
  - Any agreement restarts the debounce counter.
  - edge = filtered & ~filtered_d.
  - count increments on the cycle after filtered rises.
- States:
  - IDLE -> COUNTING when count becomes nonzero.
  - COUNTING -> RUNNING the cycle after count == TARGET_COUNT.
  - RUNNING -> COOLDOWN after exactly RUN_CYC cycles in RUNNING.
  - COOLDOWN -> IDLE after exactly COOLDOWN_CYC cycles; count is cleared to 0 on the IDLE entry cycle.
- Counting rules:
  - Edges are counted only in IDLE and COUNTING; edges during RUNNING or COOLDOWN are ignored.
  - count saturates at TARGET_COUNT.
- abort:
  - In any state, the next cycle is IDLE with count 0 and coils 0000; done is not pulsed.
  - abort has priority over a simultaneous edge or a timer expiry.
- Mode capture:
  - half_step and dir are sampled on the cycle the FSM enters RUNNING and held for the whole run.
- Coil phase table, index 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
  - Half mode: start index 0, step ±1.
  - Full mode: start index 1, step ±2, so only two-coil phases are used.
  - Index arithmetic is modulo 8 and wraps both ways.
- Step timing:
  - The start phase is driven from the first RUNNING cycle.
  - The index advances every STEP_CYC cycles.
  - coils = 0000 outside RUNNING.
- Outputs by state:
  - done: high for exactly the single cycle on which the FSM moves RUNNING -> COOLDOWN.
  - LEDs: led_red = RUNNING; led_green = IDLE or COUNTING; both LEDs are 0 in COOLDOWN.
- Buzzer:
  - Tone and blink generators reload on RUNNING entry with both outputs = 1.
  - Each toggles every TONE_HALF_CYC / BLINK_HALF_CYC cycles respectively.
  - buzzer = tone & blink & RUNNING.
- seg: shows count 0..9 with standard active-low patterns (e.g. 5 = 0010010); blank (1111111) for count > 9.

Test Plan:
Bench parameters: DEBOUNCE_CYC=4, STEP_CYC=3, RUN_CYC=60, COOLDOWN_CYC=10, TARGET_COUNT=3, TONE_HALF_CYC=2, BLINK_HALF_CYC=8.
- Reset: assert rst for 2 cycles -> coils 0000, count 0, seg 1000000, led_green 1, buzzer 0.
- Glitch rejection: 3-cycle sensor pulse -> count stays 0. A 10-cycle pulse -> count becomes 1; seg = 1111001.
- Full batch, half mode, forward: 3 clean pulses -> RUNNING; coils step 1000, 1100, 0100, ... every 3 cycles. done pulses once at cycle 60 of RUNNING. After COOLDOWN, count = 0 and state is IDLE.
- Full-step reverse: half_step=0, dir=0 at RUNNING entry -> coils 1100, 1001, 0011, 0110, 1100 (wrap). Toggling dir mid-run has no effect.
- Lock-out: 4 sensor pulses during RUNNING/COOLDOWN -> count is unchanged and no new batch starts.
- Abort and reset: abort at RUNNING cycle 20 -> next cycle coils 0000, count 0, IDLE, no done. rst asserted mid-COOLDOWN -> all outputs return to their reset values.

Source files
------------

// File: rtl/stepper_batch_ctrl.sv
// Object-batch controller: debounced IR edge counter that runs a 28BYJ-48 stepper
// for a fixed time once a batch is complete, then locks out during cooldown.
module stepper_batch_ctrl #(
  parameter int CLK_FREQ_HZ    = 25_000_000,
  parameter int TARGET_COUNT   = 5,
  parameter int COUNT_W        = 4,
  parameter int DEBOUNCE_CYC   = CLK_FREQ_HZ / 1000 * 20,
  parameter int STEP_CYC       = CLK_FREQ_HZ / 1000,
  parameter int RUN_CYC        = CLK_FREQ_HZ * 10,
  parameter int COOLDOWN_CYC   = CLK_FREQ_HZ * 2,
  parameter int TONE_HALF_CYC  = CLK_FREQ_HZ / 4000,
  parameter int BLINK_HALF_CYC = CLK_FREQ_HZ / 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sensor,
  input  logic               abort,
  input  logic               half_step,
  input  logic               dir,
  output logic [3:0]         coils,
  output logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               done,
  output logic               led_red,
  output logic               led_green,
  output logic               buzzer,
  output logic [6:0]         seg
);

  localparam int TMR_MAX = (RUN_CYC > COOLDOWN_CYC) ? RUN_CYC : COOLDOWN_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int DEB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int STEP_W  = $clog2(STEP_CYC + 1);
  localparam int TONE_W  = $clog2(TONE_HALF_CYC + 1);
  localparam int BLINK_W = $clog2(BLINK_HALF_CYC + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, COUNTING = 2'd1, RUNNING = 2'd2, COOLDOWN = 2'd3} state_t;

  state_t               state_r, state_nx;
  logic                 sync1_r, sync2_r, filt_r, filt_d_r, rise_s;
  logic [DEB_W-1:0]     deb_cnt_r;
  logic [COUNT_W-1:0]   count_r;
  logic [TMR_W-1:0]     tmr_r;
  logic                 enter_run_s, run_end_s, cool_end_s;
  logic                 half_r, dir_r;
  logic [2:0]           idx_r, step_amt_s;
  logic [STEP_W-1:0]    step_cnt_r;
  logic                 tone_r, blink_r;
  logic [TONE_W-1:0]    tone_cnt_r;
  logic [BLINK_W-1:0]   blink_cnt_r;

  function automatic logic [3:0] phase_f(input logic [2:0] idx);
    case (idx)
      3'd0:    phase_f = 4'b1000;
      3'd1:    phase_f = 4'b1100;
      3'd2:    phase_f = 4'b0100;
      3'd3:    phase_f = 4'b0110;
      3'd4:    phase_f = 4'b0010;
      3'd5:    phase_f = 4'b0011;
      3'd6:    phase_f = 4'b0001;
      3'd7:    phase_f = 4'b1001;
      default: phase_f = 4'b0000;
    endcase
  endfunction

  function automatic logic [6:0] seg_f(input logic [COUNT_W-1:0] c);
    case (c)
      COUNT_W'(0): seg_f = 7'b1000000;
      COUNT_W'(1): seg_f = 7'b1111001;
      COUNT_W'(2): seg_f = 7'b0100100;
      COUNT_W'(3): seg_f = 7'b0110000;
      COUNT_W'(4): seg_f = 7'b0011001;
      COUNT_W'(5): seg_f = 7'b0010010;
      COUNT_W'(6): seg_f = 7'b0000010;
      COUNT_W'(7): seg_f = 7'b1111000;
      COUNT_W'(8): seg_f = 7'b0000000;
      COUNT_W'(9): seg_f = 7'b0010000;
      default:     seg_f = 7'b1111111;
    endcase
  endfunction

  // Synchroniser and debounce filter; a flip needs DEBOUNCE_CYC disagreeing cycles in a row
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      filt_r    <= 1'b0;
      filt_d_r  <= 1'b0;
      deb_cnt_r <= '0;
    end else begin
      sync1_r  <= sensor;
      sync2_r  <= sync1_r;
      filt_d_r <= filt_r;
      if (sync2_r != filt_r) begin
        if (deb_cnt_r == DEB_W'(DEBOUNCE_CYC - 1)) begin
          filt_r    <= sync2_r;
          deb_cnt_r <= '0;
        end else begin
          deb_cnt_r <= deb_cnt_r + DEB_W'(1);
        end
      end else begin
        deb_cnt_r <= '0;
      end
    end
  end

  assign rise_s = filt_r & ~filt_d_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx;
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_nx    = state_r;
    enter_run_s = 1'b0;
    run_end_s   = 1'b0;
    cool_end_s  = 1'b0;
    case (state_r)
      IDLE:     if (count_r != '0) state_nx = COUNTING;
                else               state_nx = IDLE;
      COUNTING: if (count_r == COUNT_W'(TARGET_COUNT)) begin
                  state_nx    = RUNNING;
                  enter_run_s = 1'b1;
                end else begin
                  state_nx = COUNTING;
                end
      RUNNING:  if (tmr_r == TMR_W'(RUN_CYC - 1)) begin
                  state_nx  = COOLDOWN;
                  run_end_s = 1'b1;
                end else begin
                  state_nx = RUNNING;
                end
      COOLDOWN: if (tmr_r == TMR_W'(COOLDOWN_CYC - 1)) begin
                  state_nx   = IDLE;
                  cool_end_s = 1'b1;
                end else begin
                  state_nx = COOLDOWN;
                end
      default:  state_nx = IDLE;
    endcase
    if (abort) begin
      state_nx    = IDLE;
      enter_run_s = 1'b0;
      run_end_s   = 1'b0;
      cool_end_s  = 1'b0;
    end
  end

  // Object counter, saturating, live only while idle or counting
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (abort || cool_end_s) begin
      count_r <= '0;
    end else if (rise_s && (state_r == IDLE || state_r == COUNTING)
                 && (count_r < COUNT_W'(TARGET_COUNT))) begin
      count_r <= count_r + COUNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Shared RUNNING/COOLDOWN timer, restarted on each phase entry
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_r <= '0;
    end else if (enter_run_s || run_end_s) begin
      tmr_r <= '0;
    end else if (state_r == RUNNING || state_r == COOLDOWN) begin
      tmr_r <= tmr_r + TMR_W'(1);
    end else begin
      tmr_r <= '0;
    end
  end

  assign step_amt_s = half_r ? 3'd1 : 3'd2;

  // Mode capture and phase sequencer; the 3-bit index wraps modulo 8 naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      half_r     <= 1'b0;
      dir_r      <= 1'b0;
      idx_r      <= 3'd0;
      step_cnt_r <= '0;
    end else if (enter_run_s) begin
      half_r     <= half_step;
      dir_r      <= dir;
      idx_r      <= half_step ? 3'd0 : 3'd1;
      step_cnt_r <= '0;
    end else if (state_r == RUNNING) begin
      if (step_cnt_r == STEP_W'(STEP_CYC - 1)) begin
        step_cnt_r <= '0;
        idx_r      <= dir_r ? (idx_r + step_amt_s) : (idx_r - step_amt_s);
      end else begin
        step_cnt_r <= step_cnt_r + STEP_W'(1);
      end
    end else begin
      step_cnt_r <= '0;
    end
  end

  // Buzzer tone and blink gate generators
  always_ff @(posedge clk) begin
    if (rst) begin
      tone_r      <= 1'b0;
      blink_r     <= 1'b0;
      tone_cnt_r  <= '0;
      blink_cnt_r <= '0;
    end else if (enter_run_s) begin
      tone_r      <= 1'b1;
      blink_r     <= 1'b1;
      tone_cnt_r  <= '0;
      blink_cnt_r <= '0;
    end else if (state_r == RUNNING) begin
      if (tone_cnt_r == TONE_W'(TONE_HALF_CYC - 1)) begin
        tone_cnt_r <= '0;
        tone_r     <= ~tone_r;
      end else begin
        tone_cnt_r <= tone_cnt_r + TONE_W'(1);
      end
      if (blink_cnt_r == BLINK_W'(BLINK_HALF_CYC - 1)) begin
        blink_cnt_r <= '0;
        blink_r     <= ~blink_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
      end
    end else begin
      tone_cnt_r  <= tone_cnt_r;
      blink_cnt_r <= blink_cnt_r;
    end
  end

  // Output decode from registered state; done also drops on abort
  always_comb begin
    coils     = (state_r == RUNNING) ? phase_f(idx_r) : 4'b0000;
    count     = count_r;
    busy      = (state_r == RUNNING) || (state_r == COOLDOWN);
    done      = run_end_s;
    led_red   = (state_r == RUNNING);
    led_green = (state_r == IDLE) || (state_r == COUNTING);
    buzzer    = tone_r & blink_r & (state_r == RUNNING);
    seg       = seg_f(count_r);
  end

endmodule

// File: tb/tb_stepper_batch_ctrl.sv
// Randomised scoreboard bench for stepper_batch_ctrl with a cycle-level behavioural model.
module tb_stepper_batch_ctrl;

  localparam int DEB = 4, STEP = 3, RUN = 60, COOL = 10, TGT = 3, TONE = 2, BLINK = 8;
  localparam int S_IDLE = 0, S_CNT = 1, S_RUN = 2, S_COOL = 3;

  typedef struct packed {
    logic [3:0] coils;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       led_red;
    logic       led_green;
    logic       buzzer;
    logic [6:0] seg;
  } exp_t;

  logic clk = 1'b0;
  logic r_i, s_i, a_i, h_i, d_i;
  logic [3:0] coils, count;
  logic busy, done, led_red, led_green, buzzer;
  logic [6:0] seg;

  always #5 clk = ~clk;

  stepper_batch_ctrl #(
    .CLK_FREQ_HZ(1000), .TARGET_COUNT(TGT), .COUNT_W(4), .DEBOUNCE_CYC(DEB),
    .STEP_CYC(STEP), .RUN_CYC(RUN), .COOLDOWN_CYC(COOL),
    .TONE_HALF_CYC(TONE), .BLINK_HALF_CYC(BLINK)
  ) dut (
    .clk(clk), .rst(r_i), .sensor(s_i), .abort(a_i), .half_step(h_i), .dir(d_i),
    .coils(coils), .count(count), .busy(busy), .done(done),
    .led_red(led_red), .led_green(led_green), .buzzer(buzzer), .seg(seg)
  );

  logic [3:0] phase_tab [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                4'b0010, 4'b0011, 4'b0001, 4'b1001};
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  exp_t exp_q[$];
  int   vectors = 0, miscompares = 0, cyc = 0;

  // Model state: phase, object count, cycles spent in current timed phase, captured mode
  int   m_st, m_cnt, m_k;
  bit   m_f, m_fd, m_h, m_d;
  bit   hist[$];
  bit   cur_h, cur_d, jitter;

  task automatic model_edge();
    bit rise, all_dis;
    int ocnt;
    if (r_i) begin
      m_st = S_IDLE; m_cnt = 0; m_k = 0; m_f = 0; m_fd = 0; m_h = 0; m_d = 0;
      hist = {};
      repeat (DEB + 2) hist.push_back(1'b0);
      return;
    end
    rise = m_f && !m_fd;
    ocnt = m_cnt;
    if (a_i) begin
      m_st = S_IDLE; m_cnt = 0;
    end else begin
      case (m_st)
        S_IDLE, S_CNT: begin
          if (rise && m_cnt < TGT) m_cnt++;
          if (m_st == S_IDLE && ocnt != 0) m_st = S_CNT;
          else if (m_st == S_CNT && ocnt == TGT) begin
            m_st = S_RUN; m_k = 0; m_h = h_i; m_d = d_i;
          end
        end
        S_RUN:  if (m_k == RUN - 1) begin m_st = S_COOL; m_k = 0; end else m_k++;
        S_COOL: if (m_k == COOL - 1) begin m_st = S_IDLE; m_cnt = 0; end else m_k++;
        default: m_st = S_IDLE;
      endcase
    end
    // filtered flips once the last DEB synchronised samples all disagree with it
    m_fd = m_f;
    hist.push_back(s_i);
    if (hist.size() > DEB + 2) void'(hist.pop_front());
    all_dis = 1;
    for (int i = 0; i < DEB; i++) if (hist[i] == m_f) all_dis = 0;
    if (all_dis) m_f = !m_f;
  endtask

  task automatic push_expected();
    exp_t e;
    int idx;
    e = '0;
    if (m_st == S_RUN) begin
      idx = (m_h ? 0 : 1) + (m_d ? 1 : -1) * (m_h ? 1 : 2) * (m_k / STEP);
      idx = ((idx % 8) + 8) % 8;
      e.coils = phase_tab[idx];
    end
    e.count     = 4'(m_cnt);
    e.busy      = (m_st == S_RUN) || (m_st == S_COOL);
    e.done      = (m_st == S_RUN) && (m_k == RUN - 1) && !a_i;
    e.led_red   = (m_st == S_RUN);
    e.led_green = (m_st == S_IDLE) || (m_st == S_CNT);
    e.buzzer    = (m_st == S_RUN) && ((m_k / TONE) % 2 == 0) && ((m_k / BLINK) % 2 == 0);
    e.seg       = (m_cnt <= 9) ? seg_tab[m_cnt] : 7'b1111111;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input bit r, input bit s, input bit a);
    @(posedge clk);
    #1;
    model_edge();
    r_i = r; s_i = s; a_i = a; h_i = cur_h;
    d_i = (jitter && m_st == S_RUN) ? 1'($urandom_range(0, 1)) : cur_d;
    push_expected();
  endtask

  task automatic step(input bit s, input bit a);
    cycle(1'b0, s, a);
  endtask

  task automatic pulse(input int len, input int gap);
    repeat (len) step(1'b1, 1'b0);
    repeat (gap) step(1'b0, 1'b0);
  endtask

  task automatic wait_state(input int st, input int bound);
    int n = 0;
    while (m_st != st && n < bound) begin step(1'b0, 1'b0); n++; end
    if (m_st != st) begin
      miscompares++;
      $display("FAIL wait_state: still in %0d after %0d cycles, required %0d", m_st, bound, st);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set, checked on the falling edge
  always @(negedge clk) begin
    exp_t e, g;
    cyc++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = '{coils, count, busy, done, led_red, led_green, buzzer, seg};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL outputs cyc=%0d got coils=%b cnt=%0d busy=%b done=%b red=%b grn=%b bz=%b seg=%b required coils=%b cnt=%0d busy=%b done=%b red=%b grn=%b bz=%b seg=%b",
                 cyc, g.coils, g.count, g.busy, g.done, g.led_red, g.led_green, g.buzzer, g.seg,
                 e.coils, e.count, e.busy, e.done, e.led_red, e.led_green, e.buzzer, e.seg);
      end
    end
  end

  initial begin
    int n;
    r_i = 1'b1; s_i = 1'b0; a_i = 1'b0; h_i = 1'b1; d_i = 1'b1;
    cur_h = 1'b1; cur_d = 1'b1; jitter = 1'b0;

    repeat (2) cycle(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0);

    // glitch rejected, long pulse counted
    pulse(3, 10);
    pulse(10, 10);

    // batch: half-step forward, sensor pulses during the run are locked out
    pulse($urandom_range(6, 12), $urandom_range(6, 10));
    pulse($urandom_range(6, 12), $urandom_range(6, 10));
    wait_state(S_RUN, 60);
    repeat (4) pulse(5, 5);
    wait_state(S_IDLE, 200);

    // batch: full-step reverse, dir toggled while running
    cur_h = 1'b0; cur_d = 1'b0;
    repeat (3) pulse($urandom_range(6, 12), $urandom_range(6, 10));
    jitter = 1'b1;
    wait_state(S_RUN, 60);
    wait_state(S_IDLE, 200);
    jitter = 1'b0;

    // batch aborted on running cycle 20
    cur_h = 1'($urandom_range(0, 1)); cur_d = 1'($urandom_range(0, 1));
    repeat (3) pulse($urandom_range(6, 12), $urandom_range(6, 10));
    wait_state(S_RUN, 60);
    n = 0;
    while (m_k != 18 && n < 100) begin step(1'b0, 1'b0); n++; end
    step(1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0);

    // batch reset mid-cooldown
    repeat (3) pulse($urandom_range(6, 12), $urandom_range(6, 10));
    wait_state(S_COOL, 200);
    repeat (4) step(1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b0);

    // random batches with noisy sensor and occasional abort
    repeat (4) begin
      cur_h = 1'($urandom_range(0, 1)); cur_d = 1'($urandom_range(0, 1));
      n = 0;
      while (m_st != S_RUN && n < 30) begin
        pulse($urandom_range(1, 12), $urandom_range(3, 12));
        n++;
      end
      n = 0;
      while (m_st != S_IDLE && n < 200) begin
        step($urandom_range(0, 3) == 0, $urandom_range(0, 149) == 0);
        n++;
      end
      repeat (4) step(1'b0, 1'b0);
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected samples unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
